// File: rtl/ex_sequencer.sv
// EX-stage sequencer: selects the single-cycle ALU path or the multi-cycle multiply
// unit, bounds the MU wait with a timeout and returns a registered one-cycle exdone.
module ex_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int LATW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exstart,
  input  logic            ismul,
  input  logic [1:0]      mulctl_in,
  input  logic [XLEN-1:0] alures,
  input  logic [XLEN-1:0] mulres,
  input  logic            muldone,
  output logic            mulstart,
  output logic [1:0]      mulctl,
  output logic            ifuresctl,
  output logic [XLEN-1:0] exres,
  output logic            exdone,
  output logic            busy,
  output logic            errtimeout,
  output logic [LATW-1:0] lastlat
);

  localparam int WCW = $clog2(TIMEOUT);
  localparam logic [LATW-1:0] LAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r;
  logic [WCW-1:0] waitcnt_r;

  // Latency reported for a WAIT exit at count cnt is cnt+1, clamped to the counter range.
  function automatic logic [LATW-1:0] sat_lat(input logic [WCW-1:0] cnt);
    logic [31:0] inc;
    inc = 32'(cnt) + 32'd1;
    if (inc > 32'(LAT_MAX)) begin
      sat_lat = LAT_MAX;
    end else begin
      sat_lat = LATW'(inc);
    end
  endfunction

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      waitcnt_r  <= '0;
      mulstart   <= 1'b0;
      mulctl     <= 2'd0;
      ifuresctl  <= 1'b0;
      exres      <= {XLEN{1'b0}};
      exdone     <= 1'b0;
      busy       <= 1'b0;
      errtimeout <= 1'b0;
      lastlat    <= {LATW{1'b0}};
    end else begin
      mulstart <= 1'b0;
      exdone   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (exstart) begin
            busy <= 1'b1;
            if (ismul) begin
              mulctl    <= mulctl_in;
              ifuresctl <= 1'b1;
              mulstart  <= 1'b1;
              state_r   <= ISSUE;
            end else begin
              exres     <= alures;
              ifuresctl <= 1'b0;
              exdone    <= 1'b1;
              state_r   <= DONE;
            end
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          waitcnt_r <= '0;
          state_r   <= WAIT;
        end
        WAIT: begin
          // A completion in the final wait cycle takes priority over the timeout.
          if (muldone) begin
            exres   <= mulres;
            lastlat <= sat_lat(waitcnt_r);
            exdone  <= 1'b1;
            state_r <= DONE;
          end else if (waitcnt_r == WCW'(TIMEOUT - 1)) begin
            exres      <= {XLEN{1'b0}};
            errtimeout <= 1'b1;
            lastlat    <= sat_lat(waitcnt_r);
            exdone     <= 1'b1;
            state_r    <= DONE;
          end else begin
            waitcnt_r <= waitcnt_r + WCW'(1);
            state_r   <= WAIT;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_sequencer.sv
// Self-checking bench for ex_sequencer: a cycle-timeline model derived from the
// latency rules, checked every cycle, plus directed literal expectations.
module tb_ex_sequencer;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;
  localparam int LATW    = 2;
  localparam int LATMAX  = (1 << LATW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            exstart;
  logic            ismul;
  logic [1:0]      mulctl_in;
  logic [XLEN-1:0] alures;
  logic [XLEN-1:0] mulres;
  logic            muldone;
  logic            mulstart;
  logic [1:0]      mulctl;
  logic            ifuresctl;
  logic [XLEN-1:0] exres;
  logic            exdone;
  logic            busy;
  logic            errtimeout;
  logic [LATW-1:0] lastlat;

  int checks = 0;
  int errors = 0;

  ex_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .LATW(LATW)) dut (
    .clk(clk), .rst(rst), .exstart(exstart), .ismul(ismul), .mulctl_in(mulctl_in),
    .alures(alures), .mulres(mulres), .muldone(muldone), .mulstart(mulstart),
    .mulctl(mulctl), .ifuresctl(ifuresctl), .exres(exres), .exdone(exdone),
    .busy(busy), .errtimeout(errtimeout), .lastlat(lastlat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks each accepted op by cycle numbers from the latency rules.
  int              cyc = 0;
  int              t_acc = -100;
  int              t_done = 0;
  bit              mu_pend = 1'b0;
  bit              chk_en = 1'b0;
  logic            e_mulstart, e_ifu, e_exdone, e_busy, e_err;
  logic [1:0]      e_mulctl;
  logic [XLEN-1:0] e_exres;
  int              e_lat;

  function automatic int sat(input int k);
    return (k < LATMAX) ? k : LATMAX;
  endfunction

  always @(posedge clk) begin
    e_mulstart = 1'b0;
    e_exdone   = 1'b0;
    if (rst) begin
      chk_en = 1'b1; mu_pend = 1'b0; t_done = cyc; t_acc = -100;
      e_mulctl = 2'd0; e_ifu = 1'b0; e_exres = '0; e_err = 1'b0; e_lat = 0;
    end else if (cyc > t_done && exstart) begin
      if (!ismul) begin
        e_exres = alures; e_ifu = 1'b0; t_done = cyc + 1; e_exdone = 1'b1;
      end else begin
        e_mulctl = mulctl_in; e_ifu = 1'b1; t_acc = cyc; mu_pend = 1'b1;
        t_done = cyc + TIMEOUT + 2; e_mulstart = 1'b1;
      end
    end else if (mu_pend) begin
      if (muldone && cyc >= t_acc + 2) begin
        e_exres = mulres; e_lat = sat(cyc - t_acc - 1);
        t_done = cyc + 1; mu_pend = 1'b0; e_exdone = 1'b1;
      end else if (cyc == t_acc + 1 + TIMEOUT) begin
        e_exres = '0; e_err = 1'b1; e_lat = sat(TIMEOUT);
        mu_pend = 1'b0; e_exdone = 1'b1;
      end
    end
    e_busy = (cyc + 1 <= t_done);
    cyc++;
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_mulstart", 64'(mulstart), 64'(e_mulstart));
      check("m_mulctl", 64'(mulctl), 64'(e_mulctl));
      check("m_ifuresctl", 64'(ifuresctl), 64'(e_ifu));
      check("m_exres", 64'(exres), 64'(e_exres));
      check("m_exdone", 64'(exdone), 64'(e_exdone));
      check("m_busy", 64'(busy), 64'(e_busy));
      check("m_errtimeout", 64'(errtimeout), 64'(e_err));
      check("m_lastlat", 64'(lastlat), 64'(e_lat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; exstart = 1'b0; ismul = 1'b0; mulctl_in = 2'd0;
    alures = '0; mulres = '0; muldone = 1'b0;
    ticks(2);
    rst = 1'b0;
    check("reset_exres", 64'(exres), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    // ALU op
    exstart = 1'b1; ismul = 1'b0; alures = 32'h0000_00FF;
    tick(); exstart = 1'b0;
    check("alu_exdone", 64'(exdone), 64'h1);
    check("alu_exres", 64'(exres), 64'hFF);
    check("alu_busy", 64'(busy), 64'h1);
    check("alu_ifu", 64'(ifuresctl), 64'h0);
    tick();
    check("alu_exdone_off", 64'(exdone), 64'h0);
    check("alu_busy_off", 64'(busy), 64'h0);

    // MU op, muldone at t+4
    exstart = 1'b1; ismul = 1'b1; mulctl_in = 2'd2;
    tick(); exstart = 1'b0; ismul = 1'b0;
    check("mu_mulstart", 64'(mulstart), 64'h1);
    ticks(3); muldone = 1'b1; mulres = 32'hDEAD_BEEF;
    tick(); muldone = 1'b0;
    check("mu_exdone", 64'(exdone), 64'h1);
    check("mu_exres", 64'(exres), 64'hDEAD_BEEF);
    check("mu_lastlat", 64'(lastlat), 64'd3);
    check("mu_ifu", 64'(ifuresctl), 64'h1);
    check("mu_mulctl", 64'(mulctl), 64'd2);
    tick();

    // Timeout, then an ALU op with errtimeout still set
    exstart = 1'b1; ismul = 1'b1; mulctl_in = 2'd1;
    tick(); exstart = 1'b0; ismul = 1'b0;
    ticks(4);
    check("to_exdone_early", 64'(exdone), 64'h0);
    tick();
    check("to_exdone", 64'(exdone), 64'h1);
    check("to_exres", 64'(exres), 64'h0);
    check("to_err", 64'(errtimeout), 64'h1);
    tick();
    exstart = 1'b1; alures = 32'h0000_1234;
    tick(); exstart = 1'b0;
    check("to_sticky_err", 64'(errtimeout), 64'h1);
    check("to_alu_exres", 64'(exres), 64'h1234);
    tick();

    // Reset held 2 cycles mid-WAIT, late muldone ignored
    exstart = 1'b1; ismul = 1'b1; mulctl_in = 2'd3;
    tick(); exstart = 1'b0; ismul = 1'b0;
    tick(); rst = 1'b1;
    ticks(2); rst = 1'b0;
    check("rst_err", 64'(errtimeout), 64'h0);
    check("rst_mulctl", 64'(mulctl), 64'h0);
    muldone = 1'b1; mulres = 32'h5555_AAAA;
    tick(); muldone = 1'b0;
    check("rst_no_exdone", 64'(exdone), 64'h0);
    check("rst_exres", 64'(exres), 64'h0);
    tick();

    // muldone in the final WAIT cycle wins; latency 4 saturates to 3
    exstart = 1'b1; ismul = 1'b1; mulctl_in = 2'd1;
    tick(); exstart = 1'b0; ismul = 1'b0;
    ticks(4); muldone = 1'b1; mulres = 32'hCAFE_F00D;
    tick(); muldone = 1'b0;
    check("last_exdone", 64'(exdone), 64'h1);
    check("last_exres", 64'(exres), 64'hCAFE_F00D);
    check("last_err", 64'(errtimeout), 64'h0);
    check("last_lat_sat", 64'(lastlat), 64'd3);
    tick();

    // Busy collisions, spurious muldone in ISSUE, accept right after exdone
    exstart = 1'b1; ismul = 1'b1; mulctl_in = 2'd3;
    tick(); ismul = 1'b0; muldone = 1'b1; alures = 32'h0000_0011;
    tick(); muldone = 1'b0;
    check("col_no_done_wait", 64'(exdone), 64'h0);
    tick(); exstart = 1'b0; muldone = 1'b1; mulres = 32'h0000_A5A5;
    tick(); muldone = 1'b0; exstart = 1'b1; alures = 32'h0000_0077;
    check("col_exdone", 64'(exdone), 64'h1);
    check("col_exres", 64'(exres), 64'hA5A5);
    check("col_lastlat", 64'(lastlat), 64'd2);
    tick(); alures = 32'h0000_0099;
    check("col_ignored_done", 64'(exdone), 64'h0);
    tick(); exstart = 1'b0;
    check("col_next_exdone", 64'(exdone), 64'h1);
    check("col_next_exres", 64'(exres), 64'h99);
    tick();

    // Spurious muldone in IDLE
    muldone = 1'b1; mulres = 32'hFFFF_FFFF;
    tick(); muldone = 1'b0;
    check("idle_md_busy", 64'(busy), 64'h0);
    check("idle_md_exres", 64'(exres), 64'h99);
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_sequencer.md
Name: ex_sequencer

Overview:
- Sequences the EX stage of the multi-cycle core on behalf of the main controller FSM.
- On each EX entry it decides between the single-cycle ALU path and the multi-cycle multiply unit (MU).
- For MU ops it issues the start pulse and waits for completion, bounded by a timeout.
- It captures the selected result and returns a one-cycle exdone pulse, so the main FSM never stalls indefinitely.

Parameters:
- XLEN, 32, datapath/result width.
- TIMEOUT, 64, max MU wait cycles (counted in WAIT) before a forced completion; must be >= 2.
- LATW, 8, width of the saturating MU latency counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- exstart  in  1  one-cycle pulse from the main FSM on EX entry.
- ismul  in  1  1 = M-extension op (from ex decode); valid while exstart is high.
- mulctl_in  in  2  MU operation select from ex decode; valid while exstart is high.
- alures  in  XLEN  ALU result; combinationally valid in the exstart cycle.
- mulres  in  XLEN  MU result; valid while muldone is high.
- muldone  in  1  MU completion pulse; never earlier than the cycle after mulstart.
- mulstart  out  1  one-cycle MU start pulse.
- mulctl  out  2  latched MU op; held stable from ISSUE through the end of WAIT.
- ifuresctl  out  1  result-mux select: 0 = ALU, 1 = MU; latched at exstart.
- exres  out  XLEN  captured EX result.
- exdone  out  1  one-cycle completion pulse to the main FSM.
- busy  out  1  high in every state except IDLE.
- errtimeout  out  1  sticky MU-timeout flag.
- lastlat  out  LATW  latency of the last MU op: mulstart cycle to muldone cycle.

Behaviour:
- Reset: synchronous, active-high. On rst, state = IDLE and every output = 0, including exres, lastlat and errtimeout. rst mid-operation aborts immediately: no exdone is produced, and a pending muldone is ignored.
- All outputs are registered.
- IDLE:
  - exstart & !ismul: exres <= alures, ifuresctl <= 0, go to DONE.
  - exstart & ismul: mulctl <= mulctl_in, ifuresctl <= 1, go to ISSUE.
  - No exstart: stay in IDLE.
- ISSUE: mulstart = 1 for exactly this cycle. muldone is not sampled here. Always go to WAIT, with waitcnt cleared to 0.
- WAIT:
  - muldone: exres <= mulres, lastlat <= waitcnt+1 (saturating at 2^LATW-1), go to DONE.
  - !muldone and waitcnt == TIMEOUT-1: exres <= 0, errtimeout <= 1, lastlat <= saturated value, go to DONE.
  - Otherwise: waitcnt += 1, stay in WAIT.
  - muldone in the timeout cycle wins; errtimeout stays unchanged.
- DONE: exdone = 1 for this cycle only, then go to IDLE.
- exstart while busy = 1 (ISSUE, WAIT, DONE) is ignored; it is neither queued nor flagged.
- Latency:
  - ALU: exstart at cycle t gives exdone at t+1.
  - MU: exstart at t gives mulstart at t+1. muldone at t+1+k (k>=1) gives exdone at t+2+k and lastlat = k.
  - Back-to-back: the earliest next accepted exstart is the cycle after exdone.
- Hold rules:
  - exres, ifuresctl and lastlat hold until overwritten by the next op.
  - mulctl holds its last value.
  - errtimeout clears only on rst.
- muldone outside WAIT is ignored.
- waitcnt is internal, ceil(log2(TIMEOUT)) bits; it never wraps because of the timeout bound.

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT, then release → all outputs 0, state IDLE, no exdone; a later muldone=1 is ignored.
- ALU op: exstart=1, ismul=0, alures=0x0000_00FF at t → exdone=1 only at t+1, exres=0xFF, ifuresctl=0, busy=1 at t+1 only.
- MU op: exstart, ismul=1, mulctl_in=2 at t; muldone with mulres=0xDEAD_BEEF at t+4 → mulstart=1 only at t+1, mulctl=2, exdone at t+5, exres=0xDEADBEEF, lastlat=3, ifuresctl=1.
- Timeout (TIMEOUT=4): MU op with no muldone → exdone at t+6, exres=0, errtimeout=1 sticky through a following ALU op. A muldone arriving in the last WAIT cycle instead yields exres=mulres and errtimeout=0.
- Busy collisions: exstart pulses during ISSUE/WAIT/DONE → ignored, exactly one exdone per accepted op. An exstart in the cycle after exdone is accepted.
- Spurious muldone in IDLE/ISSUE, and saturation (LATW=2, muldone after 5 cycles) → no state change from the spurious pulses; lastlat=3.
